servo_frame_encoder: RTL

//  Transmit-side counterpart of the servo select decoder. Serialises a 10-bit X
//  and a 10-bit Y servo PWM value into a fixed 4-byte UART frame: X_HI, X_LO,
//  Y_HI, Y_LO. Sits between the control logic and the UART byte transmitter.
//  The X-before-Y, high-before-low byte order is mandatory: the receiver pairs

---
 rtl/servo_frame_encoder.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/servo_frame_encoder.sv
// -----------------------------------------------------------------------------
// servo_frame_encoder
//
// Serialises one 10-bit X and one 10-bit Y servo value into a fixed 4-byte
// UART frame: X_HI, X_LO, Y_HI, Y_LO. Bits [7:5] of every byte carry the servo
// tag (3'b000 for X, Y_TAG for Y). Bits [4:0] carry five bits of the value.
// The receiver pairs bytes by watching the tag change, so the bytes of a
// frame always go out in this order and are never split up.
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst        in   1   synchronous active-high reset (aborts a frame in flight)
//   xPWM       in   10  X value, captured when a request is accepted
//   yPWM       in   10  Y value, captured when a request is accepted
//   start      in   1   one-cycle request to send {xPWM, yPWM}
//   txData     out  8   byte offered to the UART transmitter
//   txValid    out  1   txData is valid
//   txReady    in   1   transmitter takes the byte when txValid & txReady
//   busy       out  1   high from frame launch until the inter-frame gap ends
//   frameDone  out  1   one-cycle pulse after Y_LO is transferred
// -----------------------------------------------------------------------------
module servo_frame_encoder #(
  parameter logic [2:0]  Y_TAG      = 3'b001,
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned GAP_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] xPWM,
  input  logic [9:0] yPWM,
  input  logic       start,
  output logic [7:0] txData,
  output logic       txValid,
  input  logic       txReady,
  output logic       busy,
  output logic       frameDone
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_X_HI = 3'd1,
    S_X_LO = 3'd2,
    S_Y_HI = 3'd3,
    S_Y_LO = 3'd4,
    S_GAP  = 3'd5
  } state_t;

  // Last counter value of the gap; unused when GAP_CYCLES is zero because the
  // GAP state is then skipped entirely.
  localparam logic [GAP_W-1:0] GAP_LAST =
    (GAP_CYCLES == 32'd0) ? '0 : GAP_W'(GAP_CYCLES - 32'd1);

  state_t           r_state;
  logic [9:0]       r_xs;
  logic [9:0]       r_ys;
  logic             r_pend;
  logic [9:0]       r_px;
  logic [9:0]       r_py;
  logic [GAP_W-1:0] r_gap;
  logic [7:0]       r_tx_data;
  logic             r_tx_valid;
  logic             r_busy;
  logic             r_done;

  state_t           w_state_nxt;
  logic [9:0]       w_xs_nxt;
  logic [9:0]       w_ys_nxt;
  logic             w_pend_nxt;
  logic [9:0]       w_px_nxt;
  logic [9:0]       w_py_nxt;
  logic [GAP_W-1:0] w_gap_nxt;
  logic [7:0]       w_tx_data_nxt;
  logic             w_tx_valid_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_xfer;

  // Byte shown in a given state, built from the frame snapshot.
  function automatic logic [7:0] encode_byte(input state_t st,
                                             input logic [9:0] xs,
                                             input logic [9:0] ys);
    logic [7:0] b;
    case (st)
      S_X_HI:  b = {3'b000, xs[9:5]};
      S_X_LO:  b = {3'b000, xs[4:0]};
      S_Y_HI:  b = {Y_TAG, ys[9:5]};
      S_Y_LO:  b = {Y_TAG, ys[4:0]};
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign w_xfer = r_tx_valid & txReady;

  // Next-state, snapshot/pending update and next registered outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_xs_nxt    = r_xs;
    w_ys_nxt    = r_ys;
    w_pend_nxt  = r_pend;
    w_px_nxt    = r_px;
    w_py_nxt    = r_py;
    w_gap_nxt   = r_gap;
    w_done_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          // A fresh request is newer than anything pending, so it replaces it.
          w_xs_nxt    = xPWM;
          w_ys_nxt    = yPWM;
          w_pend_nxt  = 1'b0;
          w_state_nxt = S_X_HI;
        end else if (r_pend) begin
          w_xs_nxt    = r_px;
          w_ys_nxt    = r_py;
          w_pend_nxt  = 1'b0;
          w_state_nxt = S_X_HI;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_X_HI: begin
        if (w_xfer) begin
          w_state_nxt = S_X_LO;
        end else begin
          w_state_nxt = S_X_HI;
        end
      end
      S_X_LO: begin
        if (w_xfer) begin
          w_state_nxt = S_Y_HI;
        end else begin
          w_state_nxt = S_X_LO;
        end
      end
      S_Y_HI: begin
        if (w_xfer) begin
          w_state_nxt = S_Y_LO;
        end else begin
          w_state_nxt = S_Y_HI;
        end
      end
      S_Y_LO: begin
        if (w_xfer) begin
          w_done_nxt = 1'b1;
          w_gap_nxt  = '0;
          if (GAP_CYCLES == 32'd0) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_GAP;
          end
        end else begin
          w_state_nxt = S_Y_LO;
        end
      end
      S_GAP: begin
        if (r_gap == GAP_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_nxt   = r_gap + GAP_W'(1);
          w_state_nxt = S_GAP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Requests arriving outside IDLE (including on the GAP->IDLE edge) are
    // parked; the newest one overwrites any older parked request and the
    // active snapshot is left alone.
    if (start && (r_state != S_IDLE)) begin
      w_pend_nxt = 1'b1;
      w_px_nxt   = xPWM;
      w_py_nxt   = yPWM;
    end else begin
      w_px_nxt = w_px_nxt;
    end

    w_tx_valid_nxt = (w_state_nxt inside {S_X_HI, S_X_LO, S_Y_HI, S_Y_LO});
    w_tx_data_nxt  = encode_byte(w_state_nxt, w_xs_nxt, w_ys_nxt);
    w_busy_nxt     = (w_state_nxt != S_IDLE);
  end

  // State, snapshot, pending request and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_xs       <= 10'd0;
      r_ys       <= 10'd0;
      r_pend     <= 1'b0;
      r_px       <= 10'd0;
      r_py       <= 10'd0;
      r_gap      <= '0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_xs       <= w_xs_nxt;
      r_ys       <= w_ys_nxt;
      r_pend     <= w_pend_nxt;
      r_px       <= w_px_nxt;
      r_py       <= w_py_nxt;
      r_gap      <= w_gap_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign txData    = r_tx_data;
  assign txValid   = r_tx_valid;
  assign busy      = r_busy;
  assign frameDone = r_done;

endmodule
